bram_arbiter: RTL and testbench

- Shares one dual-port block RAM between two requesters: m0 is the CPU data bus and m1 is the SDR sample DMA.
- Independent round-robin arbiters drive the write port (A) and the read port (B).
- Read data returns one cycle after acceptance. Same-cycle read-after-write to the same word is forwarded byte-wise.
- Sits between the bus fabric and the RAM instance; the RAM itself is unchanged.

---
 rtl/bram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_bram_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Two-master arbiter in front of a simple dual-port BRAM: writes share port A, reads share port B,
// each port with its own round-robin pointer, plus same-cycle write-to-read byte forwarding.
module bram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clka,
   input  logic                  rst,

   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [31:0]           m0_wdata,
   input  logic [3:0]            m0_be,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [31:0]           m0_rdata,

   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [31:0]           m1_wdata,
   input  logic [3:0]            m1_be,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [31:0]           m1_rdata,

   output logic [ADDR_WIDTH-1:0] ram_addra,
   output logic [31:0]           ram_dina,
   output logic [3:0]            ram_wea,
   output logic [ADDR_WIDTH-1:0] ram_addrb,
   input  logic [31:0]           ram_doutb,

   output logic [CNT_WIDTH-1:0]  contention_cnt
);

   // Per-class requests; reset masks everything so no grant is issued while rst is high.
   logic m0_wr_req, m1_wr_req, m0_rd_req, m1_rd_req;
   logic wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
   logic wr_any, rd_any;

   logic wr_ptr_q, wr_ptr_d;
   logic rd_ptr_q, rd_ptr_d;

   logic rd_pending_q, rd_pending_d;
   logic rd_owner_q, rd_owner_d;

   logic        fwd_hit_q, fwd_hit_d;
   logic [3:0]  fwd_be_q, fwd_be_d;
   logic [31:0] fwd_data_q, fwd_data_d;

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 refused;

   logic [31:0] rd_word;

   always_comb begin
      m0_wr_req = m0_req &  m0_we & ~rst;
      m1_wr_req = m1_req &  m1_we & ~rst;
      m0_rd_req = m0_req & ~m0_we & ~rst;
      m1_rd_req = m1_req & ~m1_we & ~rst;
   end

   // Round-robin: pointer 0 favours m0, 1 favours m1, only consulted when both contend.
   always_comb begin
      wr_gnt0 = m0_wr_req & (~m1_wr_req | ~wr_ptr_q);
      wr_gnt1 = m1_wr_req & (~m0_wr_req |  wr_ptr_q);
      rd_gnt0 = m0_rd_req & (~m1_rd_req | ~rd_ptr_q);
      rd_gnt1 = m1_rd_req & (~m0_rd_req |  rd_ptr_q);
      wr_any  = wr_gnt0 | wr_gnt1;
      rd_any  = rd_gnt0 | rd_gnt1;
      m0_gnt  = wr_gnt0 | rd_gnt0;
      m1_gnt  = wr_gnt1 | rd_gnt1;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (wr_gnt0) begin
         wr_ptr_d = 1'b1;
      end else if (wr_gnt1) begin
         wr_ptr_d = 1'b0;
      end
      rd_ptr_d = rd_ptr_q;
      if (rd_gnt0) begin
         rd_ptr_d = 1'b1;
      end else if (rd_gnt1) begin
         rd_ptr_d = 1'b0;
      end
   end

   // Port A drive
   always_comb begin
      ram_addra = '0;
      ram_dina  = '0;
      ram_wea   = '0;
      if (wr_gnt0) begin
         ram_addra = m0_addr;
         ram_dina  = m0_wdata;
         ram_wea   = m0_be;
      end else if (wr_gnt1) begin
         ram_addra = m1_addr;
         ram_dina  = m1_wdata;
         ram_wea   = m1_be;
      end
   end

   // Port B drive
   always_comb begin
      ram_addrb = '0;
      if (rd_gnt0) begin
         ram_addrb = m0_addr;
      end else if (rd_gnt1) begin
         ram_addrb = m1_addr;
      end
   end

   // The RAM returns the pre-write word on a same-address collision, so capture the write.
   always_comb begin
      rd_pending_d = rd_any;
      rd_owner_d   = rd_gnt1;
      fwd_hit_d    = wr_any & rd_any & (ram_addra == ram_addrb);
      fwd_be_d     = ram_wea;
      fwd_data_d   = ram_dina;
   end

   always_comb begin
      refused = (m0_wr_req & m1_wr_req) | (m0_rd_req & m1_rd_req);
      cnt_d   = cnt_q;
      if (refused && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clka) begin
      if (rst) begin
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         rd_pending_q <= 1'b0;
         rd_owner_q   <= 1'b0;
         fwd_hit_q    <= 1'b0;
         fwd_be_q     <= '0;
         fwd_data_q   <= '0;
         cnt_q        <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rd_pending_q <= rd_pending_d;
         rd_owner_q   <= rd_owner_d;
         fwd_hit_q    <= fwd_hit_d;
         fwd_be_q     <= fwd_be_d;
         fwd_data_q   <= fwd_data_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         rd_word[8*i +: 8] = (fwd_hit_q && fwd_be_q[i]) ? fwd_data_q[8*i +: 8]
                                                         : ram_doutb[8*i +: 8];
      end
   end

   // rst also kills a response still in flight from the cycle before reset.
   always_comb begin
      m0_rvalid      = rd_pending_q & ~rd_owner_q & ~rst;
      m1_rvalid      = rd_pending_q &  rd_owner_q & ~rst;
      m0_rdata       = m0_rvalid ? rd_word : 32'h0;
      m1_rdata       = m1_rvalid ? rd_word : 32'h0;
      contention_cnt = cnt_q;
   end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural read-first dual-port RAM behind it.
module tb_bram_arbiter;

   localparam int unsigned AW = 13;
   localparam int unsigned CW = 4;

   logic          clka = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [31:0]   m0_wdata, m1_wdata;
   logic [3:0]    m0_be, m1_be;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0]   m0_rdata, m1_rdata;
   logic [AW-1:0] ram_addra, ram_addrb;
   logic [31:0]   ram_dina, ram_doutb;
   logic [3:0]    ram_wea;
   logic [CW-1:0] contention_cnt;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [31:0]   bd_data = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clka = ~clka;

   bram_arbiter #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clka(clka), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
      .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
      .contention_cnt(contention_cnt)
   );

   // Read-first RAM: a same-cycle read of a written word returns the old contents.
   always @(posedge clka) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_wea[i]) mem[ram_addra][8*i +: 8] <= ram_dina[8*i +: 8];
      end
      if (bd_we) mem[bd_addr] <= bd_data;
      ram_doutb <= mem[ram_addrb];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic idle();
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
   endtask

   task automatic m0_set(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] be);
      m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be;
   endtask

   task automatic m1_set(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] be);
      m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      bd_we = 1; bd_addr = a; bd_data = d;
      tick();
      bd_we = 0;
   endtask

   logic exp_owner, prev_owner;

   initial begin
      idle();
      rst = 1;
      m0_set(1'b1, 13'd1, 32'h1, 4'hF);
      tick();
      tick();
      #2;
      check("rst_m0_gnt", m0_gnt, 0);
      check("rst_wea", ram_wea, 0);
      tick();
      rst = 0;
      idle();
      #2;
      check("rst_cnt", contention_cnt, 0);
      check("rst_m0_rvalid", m0_rvalid, 0);
      check("rst_m0_rdata", m0_rdata, 0);
      tick();

      // Single read
      preload(13'd5, 32'hDEADBEEF);
      m0_set(1'b0, 13'd5, 32'h0, 4'h0);
      #2;
      check("rd1_gnt", m0_gnt, 1);
      check("rd1_addrb", ram_addrb, 5);
      tick();
      idle();
      #2;
      check("rd1_rvalid", m0_rvalid, 1);
      check("rd1_rdata", m0_rdata, 32'hDEADBEEF);
      check("rd1_m1_rvalid", m1_rvalid, 0);
      tick();

      // Write contention, both held for four cycles
      m0_set(1'b1, 13'd1, 32'h11111111, 4'hF);
      m1_set(1'b1, 13'd2, 32'h22222222, 4'hF);
      for (int i = 0; i < 4; i++) begin
         #2;
         check("wc_m0_gnt", m0_gnt, (i % 2 == 0) ? 1 : 0);
         check("wc_m1_gnt", m1_gnt, (i % 2 == 1) ? 1 : 0);
         tick();
      end
      idle();
      #2;
      check("wc_cnt", contention_cnt, 4);
      check("wc_mem1", mem[1], 32'h11111111);
      check("wc_mem2", mem[2], 32'h22222222);
      tick();

      // Concurrent write and read on different ports
      preload(13'd4, 32'h12345678);
      m0_set(1'b1, 13'd3, 32'hAAAA5555, 4'hF);
      m1_set(1'b0, 13'd4, 32'h0, 4'h0);
      #2;
      check("cc_m0_gnt", m0_gnt, 1);
      check("cc_m1_gnt", m1_gnt, 1);
      tick();
      idle();
      #2;
      check("cc_m1_rvalid", m1_rvalid, 1);
      check("cc_m1_rdata", m1_rdata, 32'h12345678);
      check("cc_m0_rvalid", m0_rvalid, 0);
      check("cc_cnt", contention_cnt, 4);
      check("cc_mem3", mem[3], 32'hAAAA5555);
      tick();

      // Same-cycle RAW forwarding
      preload(13'd7, 32'h11223344);
      m1_set(1'b1, 13'd7, 32'hAABBCCDD, 4'b0101);
      m0_set(1'b0, 13'd7, 32'h0, 4'h0);
      tick();
      idle();
      #2;
      check("raw_rvalid", m0_rvalid, 1);
      check("raw_rdata", m0_rdata, 32'h11BB33DD);
      tick();
      m0_set(1'b0, 13'd7, 32'h0, 4'h0);
      tick();
      idle();
      #2;
      check("raw_reread", m0_rdata, 32'h11BB33DD);
      tick();

      // be=0 write is a no-op that still rotates wr_ptr
      m0_set(1'b1, 13'd3, 32'hFFFFFFFF, 4'h0);
      tick();
      m0_set(1'b1, 13'd11, 32'h0C0C0C0C, 4'hF);
      m1_set(1'b1, 13'd11, 32'h0B0B0B0B, 4'hF);
      #2;
      check("be0_m1_gnt", m1_gnt, 1);
      check("be0_m0_gnt", m0_gnt, 0);
      tick();
      idle();
      #2;
      check("be0_mem3", mem[3], 32'hAAAA5555);
      check("be0_mem11", mem[11], 32'h0B0B0B0B);

      // Consecutive writes to one address: later wins
      m0_set(1'b1, 13'd10, 32'h00000001, 4'hF);
      tick();
      idle();
      m1_set(1'b1, 13'd10, 32'h00000002, 4'hF);
      tick();
      idle();
      #2;
      check("ww_mem10", mem[10], 32'h00000002);

      // Top address passes straight through
      m0_set(1'b1, 13'h1FFF, 32'hCAFEF00D, 4'hF);
      #2;
      check("top_addra", ram_addra, 32'h1FFF);
      tick();
      m0_set(1'b0, 13'h1FFF, 32'h0, 4'h0);
      tick();
      idle();
      #2;
      check("top_rdata", m0_rdata, 32'hCAFEF00D);
      tick();

      // Reset mid-read
      m0_set(1'b1, 13'd9, 32'h99999999, 4'hF);
      tick();
      m0_set(1'b0, 13'd5, 32'h0, 4'h0);
      #2;
      check("mr_gnt", m0_gnt, 1);
      tick();
      idle();
      rst = 1;
      #2;
      check("mr_rvalid", m0_rvalid, 0);
      check("mr_rdata", m0_rdata, 0);
      tick();
      rst = 0;
      #2;
      check("mr_cnt", contention_cnt, 0);
      check("mr_rvalid_after", m0_rvalid, 0);
      m0_set(1'b1, 13'd12, 32'h0, 4'hF);
      m1_set(1'b1, 13'd13, 32'h0, 4'hF);
      #2;
      check("mr_wr_m0_gnt", m0_gnt, 1);
      check("mr_wr_m1_gnt", m1_gnt, 0);
      tick();
      m0_set(1'b0, 13'd5, 32'h0, 4'h0);
      m1_set(1'b0, 13'd4, 32'h0, 4'h0);
      #2;
      check("mr_rd_m0_gnt", m0_gnt, 1);
      check("mr_rd_m1_gnt", m1_gnt, 0);
      tick();

      // Saturation: continuous read contention, counter starts at 2
      prev_owner = 1'b0;
      exp_owner  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #2;
         check("sat_m0_gnt", m0_gnt, exp_owner ? 0 : 1);
         check("sat_m1_gnt", m1_gnt, exp_owner ? 1 : 0);
         check("sat_m0_rvalid", m0_rvalid, prev_owner ? 0 : 1);
         check("sat_m1_rvalid", m1_rvalid, prev_owner ? 1 : 0);
         check("sat_rdata", prev_owner ? m1_rdata : m0_rdata,
               prev_owner ? 32'h12345678 : 32'hDEADBEEF);
         prev_owner = exp_owner;
         exp_owner  = ~exp_owner;
         tick();
      end
      idle();
      #2;
      check("sat_last_rdata", prev_owner ? m1_rdata : m0_rdata,
            prev_owner ? 32'h12345678 : 32'hDEADBEEF);
      check("sat_cnt", contention_cnt, 15);
      tick();
      #2;
      check("sat_cnt_hold", contention_cnt, 15);
      check("sat_idle_rvalid", m0_rvalid | m1_rvalid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
